// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and default clocking
package uart_pkg;

  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD     = 115200;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Rounded clocks per bit so the bit rate error stays within half a clock.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period tick generator with synchronous clear
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick marks the final clock of the current bit period
  assign tick = !clear && (cnt_q == LAST);

  // count up, wrapping at the end of each bit; clear pins the phase to zero
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - UART transmit framer: start, 8 data LSB first, optional parity, stop bits
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD      = DEF_BAUD,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txBusy,
  output logic       tx
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  if (CLKS_PER_BIT < 2 || PARITY > 2 || PARITY < 0 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
    $error("uart_tx_engine: unsupported CLKS_PER_BIT/PARITY/STOP_BITS combination");
  end

  tx_state_e  state_q, state_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_q, stop_d;
  logic       par_q, par_d;
  logic       tick;

  // The counter is held at zero while idle so every frame starts with a fresh phase.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state_q == ST_IDLE),
    .tick (tick)
  );

  assign tx     = tx_q;
  assign txBusy = busy_q;

  // next-state and next-output logic; tx_d is the level for the upcoming bit
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    par_d   = par_q;
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (txStart) begin
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          shift_d = txData;
          idx_d   = 3'd0;
          stop_d  = 1'b0;
          par_d   = (PARITY == PAR_ODD) ? ~(^txData) : (^txData);
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      ST_DATA: begin
        if (tick) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers; reset aborts any frame and idles the line high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      shift_q <= 8'h00;
      idx_q   <= 3'd0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - directed scoreboard bench for uart_tx_engine
module tb_uart_tx_engine;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [3:0] start;
  logic [3:0] tx_w;
  logic [3:0] busy_w;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  // 0: no parity/1 stop, 1: even/1 stop, 2: odd/2 stop (all 4 clk/bit), 3: defaults
  uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD(250_000), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst(rst), .txStart(start[0]), .txData(data), .txBusy(busy_w[0]), .tx(tx_w[0]));
  uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD(250_000), .PARITY(1), .STOP_BITS(1)) u_pe (
    .clk(clk), .rst(rst), .txStart(start[1]), .txData(data), .txBusy(busy_w[1]), .tx(tx_w[1]));
  uart_tx_engine #(.CLK_FREQ(1_000_000), .BAUD(250_000), .PARITY(2), .STOP_BITS(2)) u_po (
    .clk(clk), .rst(rst), .txStart(start[2]), .txData(data), .txBusy(busy_w[2]), .tx(tx_w[2]));
  uart_tx_engine u_def (
    .clk(clk), .rst(rst), .txStart(start[3]), .txData(data), .txBusy(busy_w[3]), .tx(tx_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input int sel, input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (sel == 1) exp_q.push_back(^d);
    if (sel == 2) exp_q.push_back(~(^d));
    exp_q.push_back(1'b1);
    if (sel == 2) exp_q.push_back(1'b1);
  endtask

  // called at a falling edge: request now, accepted on the next rising edge
  task automatic start_now(input int sel, input logic [7:0] d);
    data = d;
    start[sel] = 1'b1;
    push_frame(sel, d);
    @(negedge clk);
    start[sel] = 1'b0;
    data = ~d;
  endtask

  // checks every clock of the frame, then the first idle clock; ends on that idle clock
  task automatic check_frame(input int sel, input int nper, input int glitch_at);
    int cyc = 0;
    logic e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int j = 0; j < nper; j++) begin
        if (cyc == glitch_at) begin
          data = 8'h42;
          start[sel] = 1'b1;
        end else begin
          start[sel] = 1'b0;
        end
        chk($sformatf("tx_dut%0d_cyc%0d", sel, cyc), tx_w[sel], e);
        chk($sformatf("busy_dut%0d_cyc%0d", sel, cyc), busy_w[sel], 1'b1);
        @(negedge clk);
        cyc++;
      end
    end
    start[sel] = 1'b0;
    chk($sformatf("idle_tx_dut%0d", sel), tx_w[sel], 1'b1);
    chk($sformatf("idle_busy_dut%0d", sel), busy_w[sel], 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start = 4'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      chk($sformatf("rst_tx_dut%0d", s), tx_w[s], 1'b1);
      chk($sformatf("rst_busy_dut%0d", s), busy_w[s], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // single byte, no parity: 40 busy clocks
    start_now(0, 8'h41);
    check_frame(0, 4, -1);

    // request mid-frame is ignored, and no second frame follows
    @(negedge clk);
    start_now(0, 8'h41);
    check_frame(0, 4, 13);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no_second_frame_tx", tx_w[0], 1'b1);
      chk("no_second_frame_busy", busy_w[0], 1'b0);
    end

    // back-to-back: second request on the first idle clock
    start_now(0, 8'h41);
    check_frame(0, 4, -1);
    start_now(0, 8'h42);
    check_frame(0, 4, -1);

    // even parity, then odd parity with two stop bits (48 busy clocks)
    @(negedge clk);
    start_now(1, 8'h41);
    check_frame(1, 4, -1);
    @(negedge clk);
    start_now(2, 8'h41);
    check_frame(2, 4, -1);

    // reset in DATA bit 3 aborts at once; request during reset is ignored
    @(negedge clk);
    start_now(0, 8'h41);
    exp_q.delete();
    repeat (17) @(negedge clk);
    chk("pre_rst_tx_bit3", tx_w[0], 1'b0);
    chk("pre_rst_busy", busy_w[0], 1'b1);
    rst = 1'b1;
    start[0] = 1'b1;
    #1;
    chk("async_rst_tx", tx_w[0], 1'b1);
    chk("async_rst_busy", busy_w[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", tx_w[0], 1'b1);
    chk("post_rst_busy", busy_w[0], 1'b0);
    start_now(0, 8'h55);
    check_frame(0, 4, -1);

    // default parameters: 434 clocks per bit
    @(negedge clk);
    start_now(3, 8'h41);
    check_frame(3, 434, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
